datapath: RTL and testbench

- 32-bit single-bus CPU datapath: sixteen general registers R0–R15, plus PC, IR, MAR, MDR, Y, HI, LO and a 64-bit Z (ZHI:ZLO).
- A one-hot-selected bus multiplexer and a combinational ALU connect them.
- Driven cycle-by-cycle by an external control unit (or bench) through per-register In/Out strobes.
- BusMux_Out is exported for observation.

---
 rtl/datapath.sv | 161 ++++++++++++++++
 tb/tb_datapath.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: R0-R15, PC, IR, MAR, MDR, Y, HI, LO, 64-bit Z, priority bus mux and ALU.
// Define DATAPATH_MULDIV_EN to add signed MUL (1100) and DIV (1101) to the ALU.
module datapath #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] PC_RESET = '0
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             R0_In,  R1_In,  R2_In,  R3_In,
   input  logic             R4_In,  R5_In,  R6_In,  R7_In,
   input  logic             R8_In,  R9_In,  R10_In, R11_In,
   input  logic             R12_In, R13_In, R14_In, R15_In,
   input  logic             R0_Out,  R1_Out,  R2_Out,  R3_Out,
   input  logic             R4_Out,  R5_Out,  R6_Out,  R7_Out,
   input  logic             R8_Out,  R9_Out,  R10_Out, R11_Out,
   input  logic             R12_Out, R13_Out, R14_Out, R15_Out,
   input  logic             PC_In,
   input  logic             MDR_In,
   input  logic             MAR_In,
   input  logic             IR_In,
   input  logic             Y_In,
   input  logic             Z_In,
   input  logic             HI_In,
   input  logic             LO_In,
   input  logic             PC_Out,
   input  logic             MDR_Out,
   input  logic             ZLO_Out,
   input  logic             ZHI_Out,
   input  logic             HI_Out,
   input  logic             LO_Out,
   input  logic             IncPC,
   input  logic             Read,
   input  logic [3:0]       CONTROL,
   input  logic [WIDTH-1:0] MData_In,
   output logic [WIDTH-1:0] BusMux_Out
);

   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [3:0] {
      OP_ZERO = 4'b0000, OP_ADD  = 4'b0001, OP_SUB  = 4'b0010, OP_AND  = 4'b0011,
      OP_OR   = 4'b0100, OP_SHR  = 4'b0101, OP_SHRA = 4'b0110, OP_SHL  = 4'b0111,
      OP_ROR  = 4'b1000, OP_ROL  = 4'b1001, OP_NEG  = 4'b1010, OP_NOT  = 4'b1011,
      OP_MUL  = 4'b1100, OP_DIV  = 4'b1101, OP_R14  = 4'b1110, OP_R15  = 4'b1111
   } alu_op_e;

   logic [WIDTH-1:0]   r_gpr [16];
   logic [WIDTH-1:0]   r_pc, r_ir, r_mar, r_mdr, r_y, r_hi, r_lo, r_zhi, r_zlo;

   logic [15:0]        w_r_in, w_r_out;
   logic [WIDTH-1:0]   w_bus, w_a, w_b;
   logic [SHW-1:0]     w_sh;
   logic [2*WIDTH-1:0] w_ror, w_rol, w_c;
   alu_op_e            w_op;

   assign w_r_in  = {R15_In, R14_In, R13_In, R12_In, R11_In, R10_In, R9_In, R8_In,
                     R7_In,  R6_In,  R5_In,  R4_In,  R3_In,  R2_In,  R1_In, R0_In};
   assign w_r_out = {R15_Out, R14_Out, R13_Out, R12_Out, R11_Out, R10_Out, R9_Out, R8_Out,
                     R7_Out,  R6_Out,  R5_Out,  R4_Out,  R3_Out,  R2_Out,  R1_Out, R0_Out};

   // Lowest-priority source is applied first so each later assignment overrides it.
   always_comb begin
      // NOTE: defaulting every always_comb output first keeps unselected paths from inferring latches.
      w_bus = '0;
      if (MDR_Out) w_bus = r_mdr;
      if (PC_Out)  w_bus = r_pc;
      if (ZLO_Out) w_bus = r_zlo;
      if (ZHI_Out) w_bus = r_zhi;
      if (LO_Out)  w_bus = r_lo;
      if (HI_Out)  w_bus = r_hi;
      for (int i = 15; i >= 0; i--) begin
         if (w_r_out[i]) w_bus = r_gpr[i];
      end
   end

   // PC holds PC_RESET during reset, so the bus is forced to zero explicitly.
   assign BusMux_Out = Reset ? '0 : w_bus;

   assign w_a   = r_y;
   assign w_b   = BusMux_Out;
   assign w_sh  = w_b[SHW-1:0];
   assign w_op  = alu_op_e'(CONTROL);
   assign w_ror = {w_a, w_a} >> w_sh;
   assign w_rol = {w_a, w_a} << w_sh;

`ifdef DATAPATH_MULDIV_EN
   logic signed [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod;
   logic signed [WIDTH-1:0]   w_a_s, w_b_s, w_quot, w_rem;

   assign w_a_ext = {{WIDTH{w_a[WIDTH-1]}}, w_a};
   assign w_b_ext = {{WIDTH{w_b[WIDTH-1]}}, w_b};
   assign w_prod  = w_a_ext * w_b_ext;
   assign w_a_s   = w_a;
   assign w_b_s   = w_b;
   // Divide-by-zero result is defined by the datapath, not left to the operator.
   assign w_quot  = (w_b == '0) ? '1  : w_a_s / w_b_s;
   assign w_rem   = (w_b == '0) ? w_a : w_a_s % w_b_s;
`endif

   always_comb begin
      w_c = '0;
      if (IncPC) begin
         w_c[WIDTH-1:0] = w_b + WIDTH'(1);
      end else begin
         unique case (w_op)
            OP_ADD:  w_c[WIDTH-1:0] = w_a + w_b;
            OP_SUB:  w_c[WIDTH-1:0] = w_a - w_b;
            OP_AND:  w_c[WIDTH-1:0] = w_a & w_b;
            OP_OR:   w_c[WIDTH-1:0] = w_a | w_b;
            OP_SHR:  w_c[WIDTH-1:0] = w_a >> w_sh;
            OP_SHRA: w_c[WIDTH-1:0] = $signed(w_a) >>> w_sh;
            OP_SHL:  w_c[WIDTH-1:0] = w_a << w_sh;
            OP_ROR:  w_c[WIDTH-1:0] = w_ror[WIDTH-1:0];
            OP_ROL:  w_c[WIDTH-1:0] = w_rol[2*WIDTH-1:WIDTH];
            OP_NEG:  w_c[WIDTH-1:0] = '0 - w_b;
            OP_NOT:  w_c[WIDTH-1:0] = ~w_b;
`ifdef DATAPATH_MULDIV_EN
            OP_MUL:  w_c = w_prod;
            OP_DIV:  w_c = {w_rem, w_quot};
`else
            OP_MUL, OP_DIV: w_c = '0;
`endif
            OP_ZERO, OP_R14, OP_R15: w_c = '0;
            default: w_c = '0;
         endcase
      end
   end

   // NOTE: every state register uses non-blocking assignment so all loads see the pre-edge bus.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         // NOTE: the register file is small and architecturally visible, so it is reset like any other register.
         for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
         r_pc  <= PC_RESET;
         r_ir  <= '0;
         r_mar <= '0;
         r_mdr <= '0;
         r_y   <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_zhi <= '0;
         r_zlo <= '0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (w_r_in[i]) r_gpr[i] <= w_bus;
         end
         if (PC_In)  r_pc  <= w_bus;
         if (IR_In)  r_ir  <= w_bus;
         if (MAR_In) r_mar <= w_bus;
         if (MDR_In) r_mdr <= Read ? MData_In : w_bus;
         if (Y_In)   r_y   <= w_bus;
         if (HI_In)  r_hi  <= w_bus;
         if (LO_In)  r_lo  <= w_bus;
         if (Z_In) begin
            r_zhi <= w_c[2*WIDTH-1:WIDTH];
            r_zlo <= w_c[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed sequences plus randomized control against a behavioural model.
module tb_datapath;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] r_in, r_out;
   logic        PC_In, MDR_In, MAR_In, IR_In, Y_In, Z_In, HI_In, LO_In;
   logic        PC_Out, MDR_Out, ZLO_Out, ZHI_Out, HI_Out, LO_Out;
   logic        IncPC, Read;
   logic [3:0]  CONTROL;
   logic [31:0] MData_In, BusMux_Out;

   datapath #(.WIDTH(32), .PC_RESET(32'h0)) dut (
      .Clock(Clock), .Reset(Reset),
      .R0_In(r_in[0]),   .R1_In(r_in[1]),   .R2_In(r_in[2]),   .R3_In(r_in[3]),
      .R4_In(r_in[4]),   .R5_In(r_in[5]),   .R6_In(r_in[6]),   .R7_In(r_in[7]),
      .R8_In(r_in[8]),   .R9_In(r_in[9]),   .R10_In(r_in[10]), .R11_In(r_in[11]),
      .R12_In(r_in[12]), .R13_In(r_in[13]), .R14_In(r_in[14]), .R15_In(r_in[15]),
      .R0_Out(r_out[0]),   .R1_Out(r_out[1]),   .R2_Out(r_out[2]),   .R3_Out(r_out[3]),
      .R4_Out(r_out[4]),   .R5_Out(r_out[5]),   .R6_Out(r_out[6]),   .R7_Out(r_out[7]),
      .R8_Out(r_out[8]),   .R9_Out(r_out[9]),   .R10_Out(r_out[10]), .R11_Out(r_out[11]),
      .R12_Out(r_out[12]), .R13_Out(r_out[13]), .R14_Out(r_out[14]), .R15_Out(r_out[15]),
      .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In),
      .Y_In(Y_In), .Z_In(Z_In), .HI_In(HI_In), .LO_In(LO_In),
      .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out), .ZHI_Out(ZHI_Out),
      .HI_Out(HI_Out), .LO_Out(LO_Out),
      .IncPC(IncPC), .Read(Read), .CONTROL(CONTROL), .MData_In(MData_In),
      .BusMux_Out(BusMux_Out)
   );

   always #5 Clock = ~Clock;

   int n_vec = 0;
   int n_bad = 0;

   logic [31:0] m_r [16];
   logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo, m_zhi, m_zlo;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_ctl();
      r_in = '0; r_out = '0;
      PC_In = 0; MDR_In = 0; MAR_In = 0; IR_In = 0; Y_In = 0; Z_In = 0; HI_In = 0; LO_In = 0;
      PC_Out = 0; MDR_Out = 0; ZLO_Out = 0; ZHI_Out = 0; HI_Out = 0; LO_Out = 0;
      IncPC = 0; Read = 0; CONTROL = '0; MData_In = '0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_r[i] = '0;
      m_pc = 32'h0; m_ir = '0; m_mar = '0; m_mdr = '0; m_y = '0;
      m_hi = '0; m_lo = '0; m_zhi = '0; m_zlo = '0;
   endtask

   function automatic logic [31:0] model_bus();
      if (Reset) return '0;
      for (int i = 0; i < 16; i++) if (r_out[i]) return m_r[i];
      if (HI_Out)  return m_hi;
      if (LO_Out)  return m_lo;
      if (ZHI_Out) return m_zhi;
      if (ZLO_Out) return m_zlo;
      if (PC_Out)  return m_pc;
      if (MDR_Out) return m_mdr;
      return '0;
   endfunction

   function automatic logic [63:0] model_alu(input logic [3:0] op, input logic inc,
                                             input logic [31:0] a, input logic [31:0] b);
      longint unsigned a64 = {32'h0, a};
      longint          sa  = longint'($signed(a));
      int              s   = int'(b[4:0]);
      if (inc) return {32'h0, b + 32'd1};
      case (op)
         4'd1:  return {32'h0, 32'(a64 + b)};
         4'd2:  return {32'h0, 32'(a64 - b)};
         4'd3:  return {32'h0, a & b};
         4'd4:  return {32'h0, a | b};
         4'd5:  return {32'h0, 32'(a64 / (64'd1 << s))};
         4'd6:  return {32'h0, 32'(sa >>> s)};
         4'd7:  return {32'h0, 32'(a64 * (64'd1 << s))};
         4'd8:  return {32'h0, 32'((a64 >> s) | (a64 << (32 - s)))};
         4'd9:  return {32'h0, 32'((a64 << s) | (a64 >> (32 - s)))};
         4'd10: return {32'h0, 32'(64'd0 - b)};
         4'd11: return {32'h0, ~b};
`ifdef DATAPATH_MULDIV_EN
         4'd12: return 64'(sa * longint'($signed(b)));
         4'd13: begin
            int qa = $signed(a);
            int qb = $signed(b);
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {32'(qa % qb), 32'(qa / qb)};
         end
`endif
         default: return 64'h0;
      endcase
   endfunction

   // Compares the bus against the model, then lets one clock edge apply the model's loads.
   task automatic step(input string tag);
      logic [31:0] b;
      logic [63:0] c;
      #1;
      b = model_bus();
      check(tag, BusMux_Out, b);
      c = model_alu(CONTROL, IncPC, m_y, b);
      @(posedge Clock);
      if (!Reset) begin
         for (int i = 0; i < 16; i++) if (r_in[i]) m_r[i] = b;
         if (PC_In)  m_pc  = b;
         if (IR_In)  m_ir  = b;
         if (MAR_In) m_mar = b;
         if (MDR_In) m_mdr = Read ? MData_In : b;
         if (Y_In)   m_y   = b;
         if (HI_In)  m_hi  = b;
         if (LO_In)  m_lo  = b;
         if (Z_In) begin m_zhi = c[63:32]; m_zlo = c[31:0]; end
      end
      #1;
      clear_ctl();
   endtask

   task automatic peek(input string tag, input logic [31:0] exp);
      #1;
      check(tag, BusMux_Out, exp);
   endtask

   task automatic load_mdr(input logic [31:0] v);
      Read = 1; MDR_In = 1; MData_In = v;
      step("ld_mdr");
   endtask

   task automatic alu_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      load_mdr(a);
      MDR_Out = 1; Y_In = 1; step({tag, "_y"});
      load_mdr(b);
      MDR_Out = 1; CONTROL = op; Z_In = 1; step({tag, "_z"});
      ZLO_Out = 1; peek({tag, "_zlo"}, exp_lo); step({tag, "_zlo_m"});
      ZHI_Out = 1; peek({tag, "_zhi"}, exp_hi); step({tag, "_zhi_m"});
   endtask

   initial begin
      clear_ctl();
      Reset = 1;
      model_reset();
      PC_Out = 1; r_out[3] = 1;
      peek("rst_bus", 32'h0);
      @(posedge Clock); #1;
      Reset = 0;
      clear_ctl();
      PC_Out = 1; peek("rst_pc", 32'h0); step("rst_pc_m");
      r_out[7] = 1; peek("rst_r7", 32'h0); step("rst_r7_m");

      // Register load via MDR
      load_mdr(32'h22); MDR_Out = 1; r_in[2] = 1; step("mv_r2");
      load_mdr(32'h24); MDR_Out = 1; r_in[4] = 1; step("mv_r4");
      load_mdr(32'h26); MDR_Out = 1; r_in[5] = 1; step("mv_r5");
      r_out[2] = 1; peek("r2", 32'h22); step("r2_m");
      r_out[4] = 1; peek("r4", 32'h24); step("r4_m");
      r_out[5] = 1; peek("r5", 32'h26); step("r5_m");

      // Fetch
      PC_Out = 1; MAR_In = 1; IncPC = 1; Z_In = 1; step("f1");
      ZLO_Out = 1; PC_In = 1; Read = 1; MDR_In = 1; MData_In = 32'h4A92_0000; step("f2");
      MDR_Out = 1; IR_In = 1; peek("f3_bus", 32'h4A92_0000); step("f3");
      check("ir", dut.r_ir, 32'h4A92_0000);
      check("mar", dut.r_mar, 32'h0);
      PC_Out = 1; peek("pc", 32'h1); step("pc_m");

      // ADD
      r_out[2] = 1; Y_In = 1; step("add_y");
      r_out[4] = 1; CONTROL = 4'b0001; Z_In = 1; step("add_z");
      ZLO_Out = 1; r_in[5] = 1; peek("add_bus", 32'h46); step("add_r5");
      r_out[5] = 1; peek("r5_add", 32'h46); step("r5_add_m");

      // Idle bus and priority
      peek("idle", 32'h0); step("idle_m");
      r_out[2] = 1; r_out[4] = 1; peek("prio", 32'h22); step("prio_m");
      r_out[15] = 1; HI_Out = 1; PC_Out = 1; MDR_Out = 1; peek("prio2", 32'h0); step("prio2_m");
      PC_Out = 1; MDR_Out = 1; peek("prio3", 32'h1); step("prio3_m");

      // Reset between edges; loads blocked while asserted
      #2;
      Reset = 1; r_out[5] = 1;
      #1;
      check("rst_mid_r5", dut.r_gpr[5], 32'h0);
      check("rst_mid_pc", dut.r_pc, 32'h0);
      check("rst_mid_bus", BusMux_Out, 32'h0);
      model_reset();
      clear_ctl();
      Read = 1; MDR_In = 1; MData_In = 32'h99; r_in[6] = 1;
      @(posedge Clock); @(negedge Clock);
      Reset = 0;
      clear_ctl();
      MDR_Out = 1; peek("rst_hold_mdr", 32'h0); step("rst_hold_mdr_m");
      r_out[5] = 1; peek("rst_r5", 32'h0); step("rst_r5_m");
      load_mdr(32'h55);
      MDR_Out = 1; peek("resume", 32'h55); step("resume_m");

      // ALU edge cases
      alu_case("add_wrap", 32'hFFFF_FFFF, 32'h1, 4'b0001, 32'h0, 32'h0);
      alu_case("shra",     32'h8000_0000, 32'h4, 4'b0110, 32'h0, 32'hF800_0000);
      alu_case("rol",      32'h8000_0001, 32'h1, 4'b1001, 32'h0, 32'h0000_0003);
      alu_case("ror",      32'h0000_0001, 32'h1, 4'b1000, 32'h0, 32'h8000_0000);
      alu_case("neg",      32'h0,         32'h1, 4'b1010, 32'h0, 32'hFFFF_FFFF);
      alu_case("shl32",    32'h0000_1234, 32'h20, 4'b0111, 32'h0, 32'h0000_1234);
      alu_case("sub",      32'h5,         32'h7, 4'b0010, 32'h0, 32'hFFFF_FFFE);
      alu_case("op15",     32'h5,         32'h7, 4'b1111, 32'h0, 32'h0);
`ifdef DATAPATH_MULDIV_EN
      alu_case("mul",      32'hFFFF_FFFF, 32'h2, 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      alu_case("div",      32'h7,         32'h2, 4'b1101, 32'h1, 32'h3);
      alu_case("div0",     32'h1234,      32'h0, 4'b1101, 32'h1234, 32'hFFFF_FFFF);
`else
      alu_case("mul_off",  32'hFFFF_FFFF, 32'h2, 4'b1100, 32'h0, 32'h0);
      alu_case("div_off",  32'h7,         32'h2, 4'b1101, 32'h0, 32'h0);
`endif

      // Randomized control: sparse strobes so single drivers dominate but collisions still occur
      for (int n = 0; n < 400; n++) begin
         r_in     = 16'($urandom & $urandom);
         r_out    = 16'($urandom & $urandom & $urandom & $urandom);
         PC_In    = ($urandom_range(0, 5) == 0);
         MDR_In   = ($urandom_range(0, 2) == 0);
         MAR_In   = ($urandom_range(0, 5) == 0);
         IR_In    = ($urandom_range(0, 5) == 0);
         Y_In     = ($urandom_range(0, 2) == 0);
         Z_In     = ($urandom_range(0, 1) == 0);
         HI_In    = ($urandom_range(0, 5) == 0);
         LO_In    = ($urandom_range(0, 5) == 0);
         PC_Out   = ($urandom_range(0, 7) == 0);
         MDR_Out  = ($urandom_range(0, 3) == 0);
         ZLO_Out  = ($urandom_range(0, 3) == 0);
         ZHI_Out  = ($urandom_range(0, 7) == 0);
         HI_Out   = ($urandom_range(0, 7) == 0);
         LO_Out   = ($urandom_range(0, 7) == 0);
         IncPC    = ($urandom_range(0, 7) == 0);
         Read     = 1'($urandom);
         CONTROL  = 4'($urandom);
         MData_In = $urandom;
         step("rand");
         if (n % 40 == 39) begin
            check("rand_ir", dut.r_ir, m_ir);
            check("rand_mar", dut.r_mar, m_mar);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
